monostable_array: RTL and testbench

- Multi-channel successor to the single-bit monostable edge detector.
- Per channel: optional input synchroniser, debounce/glitch filter, per-channel edge-mode select, single-cycle event pulse, retriggerable stretched pulse, and sticky event flag with clear.
- Aggregate interrupt output.
- Sits between asynchronous/noisy inputs (buttons, external strobes, cross-domain flags) and control FSMs or CSR blocks.

---
 rtl/monostable_array.sv | 136 +++++++++++++
 tb/tb_monostable_array.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/monostable_array.sv
// monostable_array
//   Multi-channel edge detector for asynchronous or noisy inputs. Each channel
//   has an optional synchroniser, a persistence (debounce) filter, an edge-mode
//   select, a one-cycle event pulse, a retriggerable stretched pulse and a
//   sticky flag with clear. An aggregate interrupt ORs the enabled sticky flags.
//
// Ports
//   clk        clock
//   async_rst  asynchronous active-high reset
//   clk_en     clock enable; every register holds while low
//   sense_i    raw channel inputs                        [CHANNELS]
//   mode_i     per channel 00 off, 01 pos, 10 neg, 11 both [2*CHANNELS]
//   clear_i    sticky-flag clear per channel             [CHANNELS]
//   irq_en_i   per-channel interrupt enable              [CHANNELS]
//   level_o    filtered level                            [CHANNELS]
//   event_o    single-cycle pulse on a selected edge     [CHANNELS]
//   stretch_o  retriggerable stretched pulse             [CHANNELS]
//   sticky_o   sticky event flags                        [CHANNELS]
//   irq_o      registered OR of (sticky_o & irq_en_i)
module monostable_array #(
  parameter int   CHANNELS       = 4,
  parameter int   SYNC_STAGES    = 2,
  parameter int   FILTER_CYCLES  = 3,
  parameter int   STRETCH_CYCLES = 4,
  parameter logic RESET_LEVEL    = 1'b0
) (
  input  logic                  clk,
  input  logic                  async_rst,
  input  logic                  clk_en,
  input  logic [CHANNELS-1:0]   sense_i,
  input  logic [2*CHANNELS-1:0] mode_i,
  input  logic [CHANNELS-1:0]   clear_i,
  input  logic [CHANNELS-1:0]   irq_en_i,
  output logic [CHANNELS-1:0]   level_o,
  output logic [CHANNELS-1:0]   event_o,
  output logic [CHANNELS-1:0]   stretch_o,
  output logic [CHANNELS-1:0]   sticky_o,
  output logic                  irq_o
);

  localparam int          W  = (STRETCH_CYCLES < 1) ? 1 : STRETCH_CYCLES;
  localparam int          SW = $clog2(W + 1);
  localparam int          FW = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
  localparam int unsigned SS = (SYNC_STAGES > 0) ? SYNC_STAGES : 1;

  logic [CHANNELS-1:0] sync_out;

  if (SYNC_STAGES > 0) begin : g_sync
    logic [CHANNELS-1:0] chain [SS];

    always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
        for (int unsigned i = 0; i < SS; i++) chain[i] <= {CHANNELS{RESET_LEVEL}};
      end else if (clk_en) begin
        chain[0] <= sense_i;
        for (int unsigned i = 1; i < SS; i++) chain[i] <= chain[i-1];
      end
    end

    assign sync_out = chain[SS-1];
  end else begin : g_nosync
    assign sync_out = sense_i;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic          level_q;
    logic          prev_q;
    logic          event_q;
    logic          sticky_q;
    logic [SW-1:0] scnt;
    logic          sel;

    if (FILTER_CYCLES > 0) begin : g_filt
      logic [FW-1:0] fcnt;

      // A new level is accepted on the F-th consecutive mismatching sample;
      // any matching sample restarts the count, discarding short glitches.
      always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
          fcnt    <= '0;
          level_q <= RESET_LEVEL;
        end else if (clk_en) begin
          if (sync_out[c] != level_q) begin
            if (fcnt == FW'(FILTER_CYCLES - 1)) begin
              level_q <= sync_out[c];
              fcnt    <= '0;
            end else begin
              fcnt <= fcnt + FW'(1);
            end
          end else begin
            fcnt <= '0;
          end
        end
      end
    end else begin : g_nofilt
      always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst)   level_q <= RESET_LEVEL;
        else if (clk_en) level_q <= sync_out[c];
      end
    end

    always_comb begin
      sel = 1'b0;
      sel = (mode_i[2*c]   &  level_q & ~prev_q) |
            (mode_i[2*c+1] & ~level_q &  prev_q);
    end

    always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
        prev_q   <= RESET_LEVEL;
        event_q  <= 1'b0;
        scnt     <= '0;
        sticky_q <= 1'b0;
      end else if (clk_en) begin
        prev_q  <= level_q;
        event_q <= sel;
        if (sel)              scnt <= SW'(W);
        else if (scnt != '0)  scnt <= scnt - SW'(1);
        // set has priority over a simultaneous clear
        sticky_q <= sel | (sticky_q & ~clear_i[c]);
      end
    end

    assign level_o[c]   = level_q;
    assign event_o[c]   = event_q;
    assign stretch_o[c] = (scnt != '0);
    assign sticky_o[c]  = sticky_q;
  end

  // Built from the registered flags, so irq_o follows sticky_o by one edge.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst)   irq_o <= 1'b0;
    else if (clk_en) irq_o <= |(sticky_o & irq_en_i);
  end

endmodule

// File: tb/tb_monostable_array.sv
module tb_monostable_array;
  localparam int   CH   = 4;
  localparam int   S    = 2;
  localparam int   F    = 3;
  localparam int   W    = 4;
  localparam logic RL   = 1'b0;
  localparam int   MAXN = 4000;

  logic            clk = 1'b0;
  logic            async_rst = 1'b0;
  logic            clk_en = 1'b1;
  logic [CH-1:0]   sense_i = '0;
  logic [2*CH-1:0] mode_i = '0;
  logic [CH-1:0]   clear_i = '0;
  logic [CH-1:0]   irq_en_i = '0;
  logic [CH-1:0]   level_o, event_o, stretch_o, sticky_o;
  logic            irq_o;

  always #5 clk = ~clk;

  monostable_array #(
    .CHANNELS(CH), .SYNC_STAGES(S), .FILTER_CYCLES(F),
    .STRETCH_CYCLES(W), .RESET_LEVEL(RL)
  ) dut (
    .clk(clk), .async_rst(async_rst), .clk_en(clk_en),
    .sense_i(sense_i), .mode_i(mode_i), .clear_i(clear_i), .irq_en_i(irq_en_i),
    .level_o(level_o), .event_o(event_o), .stretch_o(stretch_o),
    .sticky_o(sticky_o), .irq_o(irq_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hs[k]  : sense_i as captured at enabled edge k since reset
  // lvl[k] : filtered level after enabled edge k (lvl[0] = reset level)
  // A level flips when the last F synchronised samples all disagree with it.
  logic [CH-1:0] hs  [0:MAXN];
  logic [CH-1:0] lvl [0:MAXN];
  int            n = 0;
  logic [CH-1:0] m_ev = '0;
  logic [CH-1:0] m_sticky = '0;
  logic          m_irq = 1'b0;
  int            last_ev [CH];
  bit            mvalid = 0;

  function automatic logic so(input int c, input int k);
    return (k >= 1) ? hs[k][c] : RL;
  endfunction

  function automatic logic [CH-1:0] lv(input int k);
    return (k >= 0) ? lvl[k] : {CH{RL}};
  endfunction

  function automatic logic [CH-1:0] m_stretch();
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = (n - last_ev[c]) < W;
    return r;
  endfunction

  task automatic model_reset();
    n        = 0;
    lvl[0]   = {CH{RL}};
    m_ev     = '0;
    m_sticky = '0;
    m_irq    = 1'b0;
    for (int c = 0; c < CH; c++) last_ev[c] = -1000;
    mvalid   = 1;
  endtask

  task automatic model_step();
    logic [CH-1:0] pre, prv, nl, sel;
    logic all_diff;
    if (n >= MAXN - 1) begin
      $display("FAIL model_overflow: got %0d expected below %0d", n, MAXN - 1);
      $fatal(1);
    end
    m_irq = |(m_sticky & irq_en_i);
    n++;
    hs[n] = sense_i;
    pre = lv(n - 1);
    prv = lv(n - 2);
    for (int c = 0; c < CH; c++) begin
      if (F == 0) nl[c] = so(c, n - S);
      else begin
        all_diff = 1'b1;
        for (int j = 0; j < F; j++) if (so(c, n - S - j) == pre[c]) all_diff = 1'b0;
        nl[c] = all_diff ? ~pre[c] : pre[c];
      end
      sel[c] = (mode_i[2*c] & pre[c] & ~prv[c]) | (mode_i[2*c+1] & ~pre[c] & prv[c]);
      if (sel[c]) last_ev[c] = n;
      m_sticky[c] = sel[c] | (m_sticky[c] & ~clear_i[c]);
    end
    lvl[n] = nl;
    m_ev   = sel;
  endtask

  always @(posedge async_rst) model_reset();

  always @(posedge clk) begin
    if (mvalid && !async_rst && clk_en) model_step();
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("m_level",   level_o,   lvl[n]);
      chk("m_event",   event_o,   m_ev);
      chk("m_stretch", stretch_o, m_stretch());
      chk("m_sticky",  sticky_o,  m_sticky);
      chk("m_irq",     irq_o,     m_irq);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {15'd0, level_o, event_o, stretch_o, sticky_o, irq_o};
  endfunction

  task automatic freeze(input logic exp_lvl0, input logic exp_str0);
    clk_en = 1'b0;
    repeat (5) begin
      tick();
      chk("t6_frozen_lvl", level_o[0], exp_lvl0);
      chk("t6_frozen_str", stretch_o[0], exp_str0);
      chk("t6_frozen_ev", event_o[0], 1'b0);
    end
    clk_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1);
  end

  initial begin
    int e, cnt, first, second, lvseen, slo, shi;

    // 1: reset assert/release mid-cycle, then quiet
    #3 async_rst = 1'b1;
    #1 chk("t1_rst_assert", outs(), 32'd0);
    tick(); tick();
    #2 async_rst = 1'b0;
    irq_en_i = '1;
    e = 0;
    repeat (20) begin
      tick();
      e += $countones(event_o | stretch_o | sticky_o) + int'(irq_o);
    end
    chk("t1_quiet", e, 0);

    // 2: clean posedge on ch0
    mode_i[1:0] = 2'b01;
    sense_i[0]  = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("t2_lvl@%0d", k), level_o[0],   k >= 5);
      chk($sformatf("t2_ev@%0d", k),  event_o[0],   k == 6);
      chk($sformatf("t2_str@%0d", k), stretch_o[0], k >= 6 && k <= 9);
      chk($sformatf("t2_stk@%0d", k), sticky_o[0],  k >= 6);
      chk($sformatf("t2_irq@%0d", k), irq_o,        k >= 7);
    end

    // 3: glitch reject on ch1, then 3-cycle pulse accepted on both edges
    mode_i[3:2] = 2'b11;
    sense_i[1]  = 1'b1;
    tick(); tick();
    sense_i[1]  = 1'b0;
    e = 0; lvseen = 0;
    repeat (10) begin
      tick();
      e += int'(event_o[1]);
      lvseen += int'(level_o[1]);
    end
    chk("t3_glitch_ev", e, 0);
    chk("t3_glitch_lvl", lvseen, 0);
    sense_i[1] = 1'b1;
    cnt = 0; first = 0; second = 0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 4) sense_i[1] = 1'b0;
      tick();
      if (event_o[1]) begin
        cnt++;
        if (cnt == 1) first = k; else second = k;
      end
    end
    chk("t3_pulse_cnt", cnt, 2);
    chk("t3_rise_edge", first, 6);
    chk("t3_fall_edge", second, 9);

    // 4: negedge-only mode, then retrigger on ch2
    mode_i[5:4] = 2'b10;
    sense_i[2]  = 1'b1;
    e = 0;
    repeat (12) begin tick(); e += int'(event_o[2]); end
    chk("t4_rise_ignored", e, 0);
    sense_i[2] = 1'b0;
    cnt = 0; first = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (event_o[2]) begin cnt++; first = k; end
    end
    chk("t4_fall_cnt", cnt, 1);
    chk("t4_fall_edge", first, 6);
    // filtered edges are at least F apart: events at 6 and 9 give a 7-cycle stretch
    mode_i[5:4] = 2'b11;
    sense_i[2]  = 1'b1;
    cnt = 0; slo = 0; shi = 0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 4) sense_i[2] = 1'b0;
      tick();
      if (stretch_o[2]) begin
        cnt++;
        if (slo == 0) slo = k;
        shi = k;
      end
    end
    chk("t4_str_cnt", cnt, 7);
    chk("t4_str_first", slo, 6);
    chk("t4_str_last", shi, 12);

    // 5: sticky clear race on ch3
    clear_i  = '1;
    irq_en_i = 4'b1000;
    tick();
    clear_i  = '0;
    tick(); tick();
    chk("t5_cleared_stk", sticky_o, 4'h0);
    chk("t5_cleared_irq", irq_o, 1'b0);
    mode_i[7:6] = 2'b01;
    sense_i[3]  = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      if (k == 6) clear_i[3] = 1'b1;
      if (k == 8) clear_i[3] = 1'b0;
      tick();
      if (k == 6) begin
        chk("t5_race_ev", event_o[3], 1'b1);
        chk("t5_race_stk", sticky_o[3], 1'b1);
        chk("t5_race_irq", irq_o, 1'b0);
      end
      if (k == 7) begin
        chk("t5_clr_stk", sticky_o[3], 1'b0);
        chk("t5_clr_irq", irq_o, 1'b1);
      end
      if (k == 8) chk("t5_irq_fall", irq_o, 1'b0);
    end

    // 6: clk_en gating mid-filter (after edge 3) and mid-stretch (after edge 8)
    mode_i[1:0] = 2'b11;
    sense_i[0]  = 1'b0;
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (event_o[0]) first = k;
      chk($sformatf("t6_str@%0d", k), stretch_o[0], k >= 6 && k <= 9);
      chk($sformatf("t6_lvl@%0d", k), level_o[0], k < 5);
      if (k == 3) freeze(1'b1, 1'b0);
      if (k == 8) freeze(1'b0, 1'b1);
    end
    chk("t6_ev_edge", first, 6);

    // reset in the middle of a stretch aborts everything at once
    sense_i[1] = 1'b1;
    repeat (7) tick();
    chk("t7_pre_rst_str", stretch_o[1], 1'b1);
    #2 async_rst = 1'b1;
    #1 chk("t7_rst_mid", outs(), 32'd0);
    tick();
    #2 async_rst = 1'b0;
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (event_o[1] && first == 0) first = k;
    end
    chk("t7_rearm_edge", first, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
